// File: rtl/key_display_scan.sv
// key_display_scan: captures strobed 4-bit key values into a 4-entry history
// (e0 newest) and scans that history onto a 4-digit common-anode
// seven-segment display. Each slot is driven for PRESCALE cycles and is then
// followed by BLANK_CYCLES cycles with every anode off, which suppresses
// ghosting between digits. All display outputs are registered.
//
// Handshake: valid_in is a single-cycle strobe with no back-pressure. Every
// cycle in which valid_in=1 and clear=0 pushes {err_in, digit_in} into e0.
// When clear=1 the history is emptied and any same-cycle valid_in is dropped.
module key_display_scan #(
  parameter int PRESCALE     = 25000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [3:0] digit_in,
  input  logic       err_in,
  input  logic       clear,
  output logic [6:0] seg_out,
  output logic       dp_n,
  output logic [3:0] seg_en,
  output logic [2:0] count
);

  localparam int MAXC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = ($clog2(MAXC) > 0) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] counter, counter_nx;
  logic [1:0]    slot, slot_nx;

  // History entries; index 0 is the newest.
  logic [3:0] occ;
  logic [3:0] errs;
  logic [3:0] vals [4];

  // Active-low {g,f,e,d,c,b,a} pattern for one history entry.
  function automatic logic [6:0] decode(input logic o, input logic e, input logic [3:0] v);
    logic [6:0] p;
    if (!o)     p = 7'b1111111;
    else if (e) p = 7'b0111111;
    else begin
      case (v)
        4'h0: p = 7'b1000000;
        4'h1: p = 7'b1111001;
        4'h2: p = 7'b0100100;
        4'h3: p = 7'b0110000;
        4'h4: p = 7'b0011001;
        4'h5: p = 7'b0010010;
        4'h6: p = 7'b0000010;
        4'h7: p = 7'b1111000;
        4'h8: p = 7'b0000000;
        4'h9: p = 7'b0010000;
        4'hA: p = 7'b0001000;
        4'hB: p = 7'b0000011;
        4'hC: p = 7'b1000110;
        4'hD: p = 7'b0100001;
        4'hE: p = 7'b0000110;
        default: p = 7'b0001110;
      endcase
    end
    return p;
  endfunction

  // History shift register and occupancy count; clear has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ   <= '0;
      errs  <= '0;
      count <= '0;
      for (int i = 0; i < 4; i++) vals[i] <= '0;
    end else if (clear) begin
      occ   <= '0;
      count <= '0;
    end else if (valid_in) begin
      occ  <= {occ[2:0], 1'b1};
      errs <= {errs[2:0], err_in};
      for (int i = 3; i > 0; i--) vals[i] <= vals[i-1];
      vals[0] <= digit_in;
      if (count != 3'd4) count <= count + 3'd1;
    end
  end

  // Scan state register: state, per-phase cycle counter, slot index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= SHOW;
      counter <= '0;
      slot    <= '0;
    end else begin
      state   <= state_nx;
      counter <= counter_nx;
      slot    <= slot_nx;
    end
  end

  // Scan next-state: SHOW for PRESCALE cycles, then BLANK, then next slot.
  always_comb begin
    state_nx   = state;
    counter_nx = counter + 1'b1;
    slot_nx    = slot;
    case (state)
      SHOW: begin
        if (counter == SHOW_LAST) begin
          counter_nx = '0;
          if (BLANK_CYCLES == 0) slot_nx = slot + 2'd1;
          else                   state_nx = BLANK;
        end
      end
      BLANK: begin
        if (counter == BLANK_LAST) begin
          counter_nx = '0;
          slot_nx    = slot + 2'd1;
          state_nx   = SHOW;
        end
      end
      default: begin
        state_nx   = SHOW;
        counter_nx = '0;
      end
    endcase
  end

  // Registered display drive reflecting this cycle's state, slot and history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_en  <= 4'b1111;
      seg_out <= 7'b1111111;
      dp_n    <= 1'b1;
    end else if (state == SHOW) begin
      seg_en  <= ~(4'b0001 << slot);
      seg_out <= decode(occ[slot], errs[slot], vals[slot]);
      dp_n    <= !((slot == 2'd0) && occ[0]);
    end else begin
      seg_en  <= 4'b1111;
      seg_out <= 7'b1111111;
      dp_n    <= 1'b1;
    end
  end

endmodule
